// File: rtl/sequence_counter_if.sv
// Sequence counter bus: controller requests (CLR/INR) and timing outputs (T/SC_VAL).
// OVF is carried only when SC_OVF_EN is defined.
interface sequence_counter_if #(
  parameter int N_STATES = 16
);
  localparam int CNT_W = $clog2(N_STATES);

  logic                 CLR;
  logic                 INR;
  logic [N_STATES-1:0]  T;
  logic [CNT_W-1:0]     SC_VAL;
`ifdef SC_OVF_EN
  logic                 OVF;

  modport master (output CLR, INR, input T, SC_VAL, OVF);
  modport slave  (input CLR, INR, output T, SC_VAL, OVF);
`else
  modport master (output CLR, INR, input T, SC_VAL);
  modport slave  (input CLR, INR, output T, SC_VAL);
`endif
endinterface

// File: rtl/sequence_counter.sv
// BC_I sequence counter: binary step count with one-hot timing decode T.
// Optional sticky wrap flag OVF is built when SC_OVF_EN is defined.
module sequence_counter #(
  parameter int N_STATES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sequence_counter_if.slave sc
);
  localparam int               CNT_W = $clog2(N_STATES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_STATES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Out-of-range counts (only reachable by forcing) also return to 0 on INR.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (sc.CLR) begin
      cnt_d = '0;
    end else if (sc.INR) begin
      if (cnt_q >= LAST) begin
        cnt_d = '0;
        wrap  = (cnt_q == LAST);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    sc.T = '0;
    for (int k = 0; k < N_STATES; k++) begin
      if (cnt_q == CNT_W'(k)) sc.T[k] = 1'b1;
    end
  end

  assign sc.SC_VAL = cnt_q;

`ifdef SC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_q <= 1'b0;
    else if (sc.CLR) ovf_q <= 1'b0;
    else if (wrap)   ovf_q <= 1'b1;
  end

  assign sc.OVF = ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif
endmodule

// File: tb/tb_sequence_counter.sv
// Bench for sequence_counter: 16-state and 8-state instances share stimulus and
// are checked every cycle against a modulo-arithmetic model.
module tb_sequence_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic inr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  sequence_counter_if #(.N_STATES(16)) if16();
  sequence_counter_if #(.N_STATES(8))  if8();

  assign if16.CLR = clr;
  assign if16.INR = inr;
  assign if8.CLR  = clr;
  assign if8.INR  = inr;

  sequence_counter #(.N_STATES(16)) u16 (.clk(clk), .rst_n(rst_n), .sc(if16.slave));
  sequence_counter #(.N_STATES(8))  u8  (.clk(clk), .rst_n(rst_n), .sc(if8.slave));

  always #5 clk = ~clk;

  // Reference model: step index per instance, plus sticky wrap flag.
  int  m16 = 0;
  int  m8  = 0;
  bit  movf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 = 0; m8 = 0; movf = 1'b0;
    end else if (clr) begin
      m16 = 0; m8 = 0; movf = 1'b0;
    end else if (inr) begin
      if (m16 == 15) movf = 1'b1;
      m16 = (m16 + 1) % 16;
      m8  = (m8 + 1) % 8;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("T16",     32'(if16.T),             32'(1) << m16);
      chk("SC16",    32'(if16.SC_VAL),        32'(m16));
      chk("onehot16", 32'($onehot(if16.T)),   32'd1);
      chk("T8",      32'(if8.T),              32'(1) << m8);
      chk("SC8",     32'(if8.SC_VAL),         32'(m8));
`ifdef SC_OVF_EN
      chk("OVF",     32'(if16.OVF),           32'(movf));
`endif
    end
  end

  task automatic step(input bit c, input bit i);
    clr = c;
    inr = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_T",  32'(if16.T), 32'h0001);
    rst_n = 1'b1;
    chk("rst_SC", 32'(if16.SC_VAL), 32'd0);

    // Increment then hold
    repeat (3) step(0, 1);
    chk("inc3_T", 32'(if16.T), 32'h0008);
    repeat (4) step(0, 0);
    chk("hold_T", 32'(if16.T), 32'h0008);

    // Clear wins over increment at count 7
    repeat (4) step(0, 1);
    chk("at7_SC", 32'(if16.SC_VAL), 32'd7);
    step(1, 1);
    chk("clrpri_SC", 32'(if16.SC_VAL), 32'd0);
    chk("clrpri_T",  32'(if16.T), 32'h0001);

    // Wrap: 8-state instance wraps at the 8th edge, 16-state at the 16th
    repeat (7) step(0, 1);
    chk("n8_at7", 32'(if8.SC_VAL), 32'd7);
    step(0, 1);
    chk("n8_wrap", 32'(if8.SC_VAL), 32'd0);
    chk("n8_T", 32'(if8.T), 32'h01);
    repeat (7) step(0, 1);
    chk("at15_T", 32'(if16.T), 32'h8000);
    step(0, 1);
    chk("wrap_SC", 32'(if16.SC_VAL), 32'd0);
    chk("wrap_T",  32'(if16.T), 32'h0001);
`ifdef SC_OVF_EN
    chk("ovf_set", 32'(if16.OVF), 32'd1);
    step(0, 1);
    chk("ovf_hold", 32'(if16.OVF), 32'd1);
    step(1, 0);
    chk("ovf_clr", 32'(if16.OVF), 32'd0);
`else
    step(1, 0);
`endif

    // Controller flow: INR in T0..T2, CLR in T3, three times
    repeat (3) begin
      repeat (3) step(0, 1);
      chk("flow_T3", 32'(if16.T), 32'h0008);
      step(1, 0);
      chk("flow_T0", 32'(if16.T), 32'h0001);
    end

    // Asynchronous reset mid-cycle at count 5
    repeat (5) step(0, 1);
    chk("pre_rst", 32'(if16.SC_VAL), 32'd5);
    inr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_SC", 32'(if16.SC_VAL), 32'd0);
    chk("arst_T",  32'(if16.T), 32'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1);
    chk("post_rst", 32'(if16.SC_VAL), 32'd1);

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      clr = ($urandom_range(0, 7) == 0);
      inr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rnd_arst", 32'(if16.SC_VAL), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sequence_counter.md
# sequence_counter

Sequence counter (SC) for the BC_I basic-computer controller. It holds the current timing step as a binary count and drives a one-hot timing vector T. The controller's combinational logic decodes T together with D0..D7 to sequence fetch, decode and execute micro-operations. The controller advances the counter with INR and returns it to T0 with CLR at the end of each instruction.

## Interface
- N_STATES, 16, number of timing states T0..T(N_STATES-1); legal range 2..256.
- CNT_W, $clog2(N_STATES), width of the binary count; derived, not overridden.

- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear request: count goes to 0.
- INR  input  1  synchronous increment request.
- T  output  N_STATES  one-hot timing vector; T[k]=1 if and only if count==k.
- SC_VAL  output  CNT_W  current binary count.
- OVF  output  1  sticky wrap flag; present only with SC_OVF_EN.

## Operation
- Internal state is one CNT_W-bit count register, plus the OVF register when SC_OVF_EN is defined.
- T is a pure combinational decode of the count register. Exactly one bit of T is high at all times, including during and immediately after reset.
- Rising clk with rst_n=1, priority order:
  - CLR=1: count <= 0. CLR wins when CLR and INR are both 1.
  - CLR=0, INR=1, count<N_STATES-1: count <= count+1.
  - CLR=0, INR=1, count==N_STATES-1: count <= 0 (wrap-around).
  - CLR=0, INR=0: count holds.
- Count values at or above N_STATES are unreachable. If one is forced, T must be all zeros and the next INR or CLR must return count to 0.
- CLR and INR are sampled only at the clock edge. Glitches on these combinational controller outputs between edges have no effect.
- rst_n=0 forces count=0 (T=one-hot bit 0) immediately, regardless of clk, CLR and INR. Reset is released synchronously to the design by the system reset logic.

## Timing
- Latency: one clock. A change to the count and T becomes visible after the rising edge that samples INR or CLR.
- T and SC_VAL settle combinationally from the register, with no extra pipeline stage.
- Reset values: SC_VAL=0, T=16'h0001 (for N_STATES=16), OVF=0.
- Assertion of rst_n=0 mid-sequence aborts the current step asynchronously. The first edge after deassertion acts on CLR/INR from state T0.
- Typical instruction flow: INR high during T0, T1, T2 gives T3 on the fourth cycle. CLR in T3 returns the counter to T0 on the next edge.

## Configuration
- SC_OVF_EN defined:
  - Adds output OVF.
  - OVF is set on the edge where CLR=0, INR=1 and count==N_STATES-1.
  - OVF is cleared by rst_n=0 or by any edge with CLR=1.
  - OVF otherwise holds, and setting it does not alter counting.
- SC_OVF_EN undefined: OVF port and register are absent. Wrap-around behaviour is unchanged.

## Test plan
- Reset: drive rst_n=0 asynchronously between clock edges with count=5 -> T=16'h0001 and SC_VAL=0 at once, without waiting for a clock edge.
- Increment: INR=1 for 3 edges from reset -> T steps 0001, 0002, 0004, 0008. Then INR=0 for 4 edges -> T holds 16'h0008.
- Clear priority: at count=7, CLR=1 and INR=1 on the same edge -> SC_VAL=0, T=16'h0001.
- Wrap: INR=1 for 16 consecutive edges from 0 -> SC_VAL returns to 0 and T=16'h0001. With SC_OVF_EN, OVF=1 after the 16th edge, and one CLR edge returns OVF to 0.
- Controller flow: INR during T0..T2, CLR at T3, repeated 3 times -> T sequence 1,2,4,8,1,... with no cycle where T is zero or multi-hot.
- Parameter: N_STATES=8 -> the 8th INR edge wraps SC_VAL from 7 to 0, and T is 8 bits wide.
